// File: rtl/rvb_pkg.sv
// Shared types and encodings for the bit-count/sign-extend sequencer.
// Provides the FSM state type, opcode/funct constants and rs2 op codes.
package rvb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DRAIN
    } state_t;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] F7_BITCNT     = 7'b0110000;
    localparam logic [2:0] F3_BITCNT     = 3'b001;

    localparam logic [4:0] RS2_CLZ      = 5'd0;
    localparam logic [4:0] RS2_CTZ      = 5'd1;
    localparam logic [4:0] RS2_PCNT     = 5'd2;
    localparam logic [4:0] RS2_BMATFLIP = 5'd3;
    localparam logic [4:0] RS2_SEXTB    = 5'd4;
    localparam logic [4:0] RS2_SEXTH    = 5'd5;

endpackage

// File: rtl/rvb_bitcnt_dec.sv
// Combinational decoder: raw instruction word -> legality + unit control bits.
// Ports: i_insn (32b word); o_legal, o_insn3, o_insn20, o_insn21, o_insn22.
module rvb_bitcnt_dec
    import rvb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BMAT = 0
) (
    input  logic [31:0] i_insn,
    output logic        o_legal,
    output logic        o_insn3,
    output logic        o_insn20,
    output logic        o_insn21,
    output logic        o_insn22
);

    localparam logic W_RV64 = (XLEN == 64);
    localparam logic W_BMAT = (XLEN == 64) && (BMAT != 0);

    logic [4:0] w_rs2;
    logic       w_wmode;
    logic       w_opc_ok;
    logic       w_fn_ok;
    logic       w_rs2_ok;

    assign w_rs2   = i_insn[24:20];
    assign w_wmode = i_insn[3];

    always_comb begin
        w_opc_ok = (i_insn[6:0] == OPC_OP_IMM) ||
                   (W_RV64 && (i_insn[6:0] == OPC_OP_IMM_32));
        w_fn_ok  = (i_insn[31:25] == F7_BITCNT) &&
                   (i_insn[14:12] == F3_BITCNT);
        w_rs2_ok = 1'b0;
        case (w_rs2)
            RS2_CLZ, RS2_CTZ, RS2_PCNT: w_rs2_ok = 1'b1;
            // No W-form exists for sign-extend or bit-matrix flip
            RS2_SEXTB, RS2_SEXTH:       w_rs2_ok = !w_wmode;
            RS2_BMATFLIP:               w_rs2_ok = W_BMAT && !w_wmode;
            default:                    w_rs2_ok = 1'b0;
        endcase
    end

    assign o_legal  = w_opc_ok && w_fn_ok && w_rs2_ok;
    assign o_insn3  = i_insn[3];
    assign o_insn20 = i_insn[20];
    assign o_insn21 = i_insn[21];
    assign o_insn22 = i_insn[22];

endmodule

// File: rtl/rvb_bitcnt_ctrl.sv
// Initiator-side sequencer for the bit-count/sign-extend unit.
// Ports: clk/rst_n/flush; req_* from decode; unit_din_*/unit_dout_* to the
// unit; wb_* writeback port; ops_cnt counts completed legal ops.
module rvb_bitcnt_ctrl
    import rvb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BMAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_insn,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [4:0]      req_rd,
    output logic            unit_din_valid,
    input  logic            unit_din_ready,
    output logic [XLEN-1:0] unit_din_rs1,
    output logic            unit_din_insn3,
    output logic            unit_din_insn20,
    output logic            unit_din_insn21,
    output logic            unit_din_insn22,
    input  logic            unit_dout_valid,
    output logic            unit_dout_ready,
    input  logic [XLEN-1:0] unit_dout_rd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_err,
    output logic [31:0]     ops_cnt
);

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_rs1;
    logic            r_i3;
    logic            r_i20;
    logic            r_i21;
    logic            r_i22;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_err;
    logic [31:0]     r_ops_cnt;

    logic w_legal;
    logic w_d3;
    logic w_d20;
    logic w_d21;
    logic w_d22;

    logic w_req_ready;
    logic w_din_valid;
    logic w_dout_ready;
    logic w_wb_valid;
    logic w_accept;
    logic w_capture;
    logic w_cnt_inc;

    rvb_bitcnt_dec #(
        .XLEN (XLEN),
        .BMAT (BMAT)
    ) u_dec (
        .i_insn   (req_insn),
        .o_legal  (w_legal),
        .o_insn3  (w_d3),
        .o_insn20 (w_d20),
        .o_insn21 (w_d21),
        .o_insn22 (w_d22)
    );

    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_din_valid  = 1'b0;
        w_dout_ready = 1'b0;
        w_wb_valid   = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_cnt_inc    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_req_ready = !flush;
                if (req_valid && !flush) begin
                    w_accept = 1'b1;
                    w_next   = w_legal ? S_ISSUE : S_WB;
                end
            end
            S_ISSUE: begin
                w_din_valid  = 1'b1;
                w_dout_ready = 1'b1;
                if (flush) begin
                    // An issued op with no result yet must be drained
                    if (unit_din_ready && !unit_dout_valid)
                        w_next = S_DRAIN;
                    else
                        w_next = S_IDLE;
                end else if (unit_din_ready && unit_dout_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_WB;
                end else if (unit_din_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_dout_ready = 1'b1;
                if (flush) begin
                    // Result arriving this cycle is consumed and dropped
                    w_next = unit_dout_valid ? S_IDLE : S_DRAIN;
                end else if (unit_dout_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_WB;
                end
            end
            S_WB: begin
                w_wb_valid = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (wb_ready) begin
                    w_cnt_inc = !r_err;
                    w_next    = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_dout_ready = 1'b1;
                if (unit_dout_valid)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rs1     <= '0;
            r_i3      <= 1'b0;
            r_i20     <= 1'b0;
            r_i21     <= 1'b0;
            r_i22     <= 1'b0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_err     <= 1'b0;
            r_ops_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rd  <= req_rd;
                r_err <= !w_legal;
                if (w_legal) begin
                    r_rs1 <= req_rs1;
                    r_i3  <= w_d3;
                    r_i20 <= w_d20;
                    r_i21 <= w_d21;
                    r_i22 <= w_d22;
                end else begin
                    r_wb_data <= '0;
                end
            end
            if (w_capture)
                r_wb_data <= unit_dout_rd;
            if (w_cnt_inc)
                r_ops_cnt <= r_ops_cnt + 32'd1;
        end
    end

    // Gate with rst_n so the port reads 0 while reset is held
    assign req_ready       = w_req_ready && rst_n;
    assign unit_din_valid  = w_din_valid;
    assign unit_dout_ready = w_dout_ready;
    assign unit_din_rs1    = r_rs1;
    assign unit_din_insn3  = r_i3;
    assign unit_din_insn20 = r_i20;
    assign unit_din_insn21 = r_i21;
    assign unit_din_insn22 = r_i22;
    assign wb_valid        = w_wb_valid;
    assign wb_rd           = r_rd;
    assign wb_data         = r_wb_data;
    assign wb_err          = r_err;
    assign ops_cnt         = r_ops_cnt;

endmodule

// File: tb/tb_rvb_bitcnt_ctrl.sv
// Directed testbench for rvb_bitcnt_ctrl (XLEN=64, BMAT=0).
// Vector table for single ops plus sequences for stalls, flush and reset.
module tb_rvb_bitcnt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = '0;
    logic [63:0] req_rs1 = '0;
    logic [4:0]  req_rd = '0;
    logic        unit_din_valid;
    logic        unit_din_ready = 1'b1;
    logic [63:0] unit_din_rs1;
    logic        unit_din_insn3;
    logic        unit_din_insn20;
    logic        unit_din_insn21;
    logic        unit_din_insn22;
    logic        unit_dout_valid = 1'b1;
    logic        unit_dout_ready;
    logic [63:0] unit_dout_rd = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_err;
    logic [31:0] ops_cnt;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    rvb_bitcnt_ctrl #(
        .XLEN (64),
        .BMAT (0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_insn        (req_insn),
        .req_rs1         (req_rs1),
        .req_rd          (req_rd),
        .unit_din_valid  (unit_din_valid),
        .unit_din_ready  (unit_din_ready),
        .unit_din_rs1    (unit_din_rs1),
        .unit_din_insn3  (unit_din_insn3),
        .unit_din_insn20 (unit_din_insn20),
        .unit_din_insn21 (unit_din_insn21),
        .unit_din_insn22 (unit_din_insn22),
        .unit_dout_valid (unit_dout_valid),
        .unit_dout_ready (unit_dout_ready),
        .unit_dout_rd    (unit_dout_rd),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .wb_err          (wb_err),
        .ops_cnt         (ops_cnt)
    );

    typedef struct {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        legal;
        logic [3:0]  bits;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic [31:0] insn, logic [63:0] rs1,
                                logic [4:0] rd, logic [63:0] res,
                                logic legal, logic [3:0] bits);
        vec_t v;
        v.insn = insn; v.rs1 = rs1; v.rd = rd;
        v.res = res; v.legal = legal; v.bits = bits;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_insn = v.insn;
        req_rs1 = v.rs1;
        req_rd = v.rd;
        unit_dout_rd = v.res;
        #1 chk("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (v.legal) begin
            chk("din_valid", unit_din_valid, 1);
            chk("wb_valid_c1", wb_valid, 0);
            chk("din_rs1", unit_din_rs1, v.rs1);
            chk("din_bits", {unit_din_insn3, unit_din_insn20,
                             unit_din_insn21, unit_din_insn22}, v.bits);
            @(negedge clk);
            #1;
            chk("wb_valid", wb_valid, 1);
            chk("wb_rd", wb_rd, v.rd);
            chk("wb_data", wb_data, v.res);
            chk("wb_err", wb_err, 0);
            exp_cnt++;
        end else begin
            chk("ill_wb_valid", wb_valid, 1);
            chk("ill_wb_err", wb_err, 1);
            chk("ill_wb_data", wb_data, 0);
            chk("ill_wb_rd", wb_rd, v.rd);
            chk("ill_din_valid", unit_din_valid, 0);
        end
        @(negedge clk);
        #1;
        chk("wb_valid_done", wb_valid, 0);
        chk("ops_cnt", ops_cnt, exp_cnt);
    endtask

    initial begin
        // bits = {insn3, insn20, insn21, insn22}
        vecs[0]  = mk(32'h60011013, 64'hF0, 5'd7, 64'd56, 1, 4'b0000);
        vecs[1]  = mk(32'h60111013, 64'h100, 5'd3, 64'd8, 1, 4'b0100);
        vecs[2]  = mk(32'h60211013, 64'hFF00FF, 5'd10, 64'd16, 1, 4'b0010);
        vecs[3]  = mk(32'h60411013, 64'h80, 5'd11,
                      64'hFFFF_FFFF_FFFF_FF80, 1, 4'b0001);
        vecs[4]  = mk(32'h60511013, 64'h7FFF, 5'd12, 64'h7FFF, 1, 4'b0101);
        vecs[5]  = mk(32'h6021101B, 64'hFFFF_FFFF_0000_000F, 5'd13,
                      64'd4, 1, 4'b1010);
        vecs[6]  = mk(32'h6001101B, 64'h1, 5'd14, 64'd31, 1, 4'b1000);
        vecs[7]  = mk(32'h60611013, 64'h5, 5'd5, 64'd9, 0, 4'b0000);
        vecs[8]  = mk(32'h60311013, 64'h5, 5'd6, 64'd9, 0, 4'b0000);
        vecs[9]  = mk(32'h6041101B, 64'h5, 5'd8, 64'd9, 0, 4'b0000);
        vecs[10] = mk(32'h60010013, 64'h5, 5'd9, 64'd9, 0, 4'b0000);
        vecs[11] = mk(32'h40011013, 64'h5, 5'd1, 64'd9, 0, 4'b0000);
        vecs[12] = mk(32'h60011033, 64'h5, 5'd2, 64'd9, 0, 4'b0000);

        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_din_valid", unit_din_valid, 0);
        chk("rst_dout_ready", unit_dout_ready, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_ops_cnt", ops_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Backpressure: din stalled 3 cycles, then wb stalled 2 cycles
        @(negedge clk);
        req_valid = 1'b1;
        req_insn = 32'h60111013;
        req_rs1 = 64'hDEAD_BEEF_0000_1000;
        req_rd = 5'd21;
        unit_din_ready = 1'b0;
        unit_dout_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_rs1 = '0;
            #1;
            chk("bp_din_valid", unit_din_valid, 1);
            chk("bp_din_rs1", unit_din_rs1, 64'hDEAD_BEEF_0000_1000);
            chk("bp_din_i20", unit_din_insn20, 1);
            chk("bp_wb_valid", wb_valid, 0);
        end
        unit_din_ready = 1'b1;
        unit_dout_valid = 1'b1;
        unit_dout_rd = 64'd12;
        wb_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            unit_dout_rd = 64'd99;
            #1;
            chk("bp_wb_hold_valid", wb_valid, 1);
            chk("bp_wb_hold_rd", wb_rd, 5'd21);
            chk("bp_wb_hold_data", wb_data, 64'd12);
        end
        wb_ready = 1'b1;
        exp_cnt++;
        @(negedge clk);
        #1;
        chk("bp_wb_done", wb_valid, 0);
        chk("bp_ops_cnt", ops_cnt, exp_cnt);

        // Flush in WAIT -> DRAIN, result discarded
        @(negedge clk);
        req_valid = 1'b1;
        req_insn = 32'h60211013;
        req_rs1 = 64'h3;
        req_rd = 5'd4;
        unit_dout_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("fw_din_valid", unit_din_valid, 1);
        @(negedge clk);
        #1;
        chk("fw_wait_din", unit_din_valid, 0);
        chk("fw_wait_dout_rdy", unit_dout_ready, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fw_drain_dout_rdy", unit_dout_ready, 1);
        chk("fw_drain_wb", wb_valid, 0);
        chk("fw_drain_req_rdy", req_ready, 0);
        @(negedge clk);
        #1;
        chk("fw_drain2_dout_rdy", unit_dout_ready, 1);
        unit_dout_valid = 1'b1;
        unit_dout_rd = 64'd77;
        @(negedge clk);
        unit_dout_valid = 1'b0;
        #1;
        chk("fw_idle_wb", wb_valid, 0);
        chk("fw_idle_req_rdy", req_ready, 1);
        chk("fw_idle_dout_rdy", unit_dout_ready, 0);
        chk("fw_ops_cnt", ops_cnt, exp_cnt);
        unit_dout_valid = 1'b1;

        // Flush in WB
        @(negedge clk);
        req_valid = 1'b1;
        req_insn = 32'h60011013;
        req_rs1 = 64'h1;
        req_rd = 5'd15;
        unit_dout_rd = 64'd63;
        wb_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 chk("fwb_wb_valid", wb_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fwb_wb_drop", wb_valid, 0);
        chk("fwb_ops_cnt", ops_cnt, exp_cnt);
        wb_ready = 1'b1;

        // Async reset mid-ISSUE
        @(negedge clk);
        req_valid = 1'b1;
        req_insn = 32'h60011013;
        req_rs1 = 64'hABCD;
        req_rd = 5'd19;
        unit_din_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("rs_issue", unit_din_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_din_valid", unit_din_valid, 0);
        chk("rs_dout_ready", unit_dout_ready, 0);
        chk("rs_req_ready", req_ready, 0);
        chk("rs_wb_valid", wb_valid, 0);
        chk("rs_din_rs1", unit_din_rs1, 0);
        chk("rs_wb_rd", wb_rd, 0);
        chk("rs_ops_cnt", ops_cnt, 0);
        exp_cnt = '0;
        unit_din_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap
        @(negedge clk);
        force dut.r_ops_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_ops_cnt;
        #1 chk("wrap_preload", ops_cnt, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        apply_vec(vecs[0]);
        chk("wrap_zero", ops_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rvb_bitcnt_ctrl.md
Name: rvb_bitcnt_ctrl

Overview:
Initiator-side sequencer for the bit-count/sign-extend execution unit; it drives that unit's din/dout valid-ready interface.
- Accepts raw RV instruction words plus rs1/rd from the core's decode stage.
- Decodes the CLZ/CTZ/PCNT/BMATFLIP/SEXT.B/SEXT.H (and W-variant) encodings into the unit's insn3/20/21/22 control bits.
- Issues one operation at a time, captures the result and presents it on a writeback port with the destination register tag.
- Flags illegal encodings; supports pipeline flush; counts completed operations.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
BMAT, 0, 1 = BMATFLIP is legal; only honoured when XLEN==64.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
flush  input  1  abort the in-flight op; the request port is blocked this cycle.
req_valid  input  1  decode offers an instruction.
req_ready  output  1  controller accepts the instruction.
req_insn  input  32  raw instruction word.
req_rs1  input  XLEN  rs1 operand value.
req_rd  input  5  destination register index.
unit_din_valid  output  1  operation presented to the unit.
unit_din_ready  input  1  unit accepts the operation.
unit_din_rs1  output  XLEN  operand to the unit.
unit_din_insn3  output  1  W-mode bit (insn[3]).
unit_din_insn20  output  1  insn[20].
unit_din_insn21  output  1  insn[21].
unit_din_insn22  output  1  insn[22].
unit_dout_valid  input  1  unit result valid.
unit_dout_ready  output  1  controller accepts the result.
unit_dout_rd  input  XLEN  unit result.
wb_valid  output  1  writeback entry valid.
wb_ready  input  1  writeback port accepts.
wb_rd  output  5  destination register.
wb_data  output  XLEN  result; 0 when wb_err=1.
wb_err  output  1  illegal-instruction indication.
ops_cnt  output  32  count of completed legal ops; wraps at 2^32.

Behaviour:
Reset values:
- State IDLE.
- All valid/ready outputs 0.
- wb_rd, wb_data, wb_err, ops_cnt, the operand register and the control-bit registers all 0.

Decode (legal = all of the following):
- insn[31:25]=0110000, insn[14:12]=001.
- Opcode: either insn[6:0]=0010011, or insn[6:0]=0011011 with XLEN==64.
- rs2 field insn[24:20] ∈ {0,1,2,4,5}, or rs2=3 with XLEN==64 && BMAT && insn[3]=0.
- rs2 ∈ {3,4,5} with insn[3]=1 is illegal.
- Control bits are taken directly from insn bits 3/20/21/22 and registered on accept.

FSM states IDLE, ISSUE, WAIT, WB, DRAIN:
- IDLE: req_ready=!flush.
  - Legal handshake → latch operands and rd → ISSUE.
  - Illegal handshake → WB with wb_err=1, wb_data=0.
- ISSUE: unit_din_valid=1, unit_dout_ready=1.
  - din handshake and dout handshake in the same cycle (combinational unit) → capture unit_dout_rd → WB.
  - din handshake only → WAIT.
  - Otherwise hold; operands stay stable while din_valid is high.
- WAIT: unit_din_valid=0, unit_dout_ready=1.
  - dout handshake → capture → WB.
- WB: wb_valid=1.
  - wb handshake → IDLE; ops_cnt increments only if wb_err=0.
  - No back-to-back accept: req_ready=0 in WB.
- Latency for a combinational unit with wb_ready=1: accept at cycle 0, din handshake at cycle 1, wb_valid at cycle 2; one op every 3 cycles. Illegal op: wb_valid at cycle 1.

Flush (has priority over every other transition in the same cycle):
- ISSUE without din handshake → IDLE, nothing issued.
- ISSUE with din handshake but no dout handshake, or WAIT → DRAIN.
- WB → IDLE, wb_valid drops, ops_cnt unchanged.
- Any other state → no effect.

DRAIN:
- unit_dout_ready=1; the result is discarded.
- On dout handshake → IDLE.
- A flush while in DRAIN has no effect.

Asynchronous reset in any state → IDLE immediately; any result in flight is lost.

Decomposition:
- Shared package rvb_pkg:
  - state enum (IDLE, ISSUE, WAIT, WB, DRAIN);
  - constants OPC_OP_IMM=7'b0010011, OPC_OP_IMM_32=7'b0011011, F7_BITCNT=7'b0110000, F3_BITCNT=3'b001;
  - rs2 codes CLZ=0, CTZ=1, PCNT=2, BMATFLIP=3, SEXTB=4, SEXTH=5.
- One combinational sub-module, rvb_bitcnt_dec: insn → {legal, insn3, insn20, insn21, insn22}.

Test Plan:
- CLZ, XLEN=64: insn=0x60011013 (clz x0/x2), rs1=0x0000_0000_0000_00F0, rd=7, unit returns 56 in the same cycle → wb_valid at cycle 2, wb_rd=7, wb_data=56, wb_err=0, ops_cnt=1.
- PCNTW, XLEN=64: opcode 0011011, rs2=2 → unit_din_insn3=1, insn21=1, insn20=0, insn22=0 observed at the din handshake.
- Illegal encodings: rs2=6, or BMATFLIP with BMAT=0 → wb_err=1, wb_data=0 at cycle 1; unit_din_valid never asserted; ops_cnt unchanged.
- Backpressure: unit_din_ready low for 3 cycles, then wb_ready low for 2 cycles → din_valid held with operands stable; wb_valid, wb_rd and wb_data held stable until accepted.
- Flush: in WAIT (unit_dout_valid delayed 4 cycles) → DRAIN, unit_dout_ready stays 1, result discarded, no wb_valid, return to IDLE. Flush in WB → wb_valid deasserts next cycle.
- Reset and wrap: rst_n asserted mid-ISSUE → all outputs 0 asynchronously. With ops_cnt preloaded to 0xFFFF_FFFF via force, one legal op → ops_cnt=0.
